// File: rtl/ov7670_dvp_source.sv
// OV7670-style DVP transmitter: VSYNC/HREF framing with RGB444 bytes from an
// internal pattern generator. Outputs are registered decodes of the frame FSM.
//
// state    | meaning
// ---------+---------------------------------------------------------
// S_IDLE   | waiting for en; counters held at zero
// S_VSYNC  | VS_LINES line periods with VSYNC high
// S_VBACK  | V_BACK blank line periods after sync
// S_ACTIVE | V_ACTIVE lines, HREF high for the first 2*H_ACTIVE clocks
// S_VFRONT | V_FRONT blank line periods; en sampled on the last clock
module ov7670_dvp_source #(
   parameter int H_ACTIVE = 640,
   parameter int V_ACTIVE = 480,
   parameter int H_BLANK  = 144,
   parameter int VS_LINES = 3,
   parameter int V_BACK   = 17,
   parameter int V_FRONT  = 10
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       en,
   input  logic [1:0] pattern_sel,
   output logic       VSYNC,
   output logic       HREF,
   output logic [7:0] D,
   output logic       frame_done,
   output logic [7:0] frame_cnt
);

   localparam int L     = 2*H_ACTIVE + H_BLANK;
   localparam int HW    = $clog2(L);
   localparam int MAX1  = (VS_LINES > V_BACK) ? VS_LINES : V_BACK;
   localparam int MAX2  = (V_ACTIVE > V_FRONT) ? V_ACTIVE : V_FRONT;
   localparam int MAXL  = (MAX1 > MAX2) ? MAX1 : MAX2;
   localparam int LW    = $clog2(MAXL + 1);
   localparam int BAR_W = H_ACTIVE / 8;
   localparam int BW    = $clog2(BAR_W + 1);

   localparam logic [HW-1:0] H_LAST   = HW'(L - 1);
   localparam logic [HW-1:0] H_HREF   = HW'(2*H_ACTIVE);
   localparam logic [BW-1:0] BAR_LAST = BW'(BAR_W - 1);

   typedef enum logic [2:0] {
      S_IDLE, S_VSYNC, S_VBACK, S_ACTIVE, S_VFRONT
   } state_t;

   state_t        state, state_nx;
   logic [HW-1:0] h, h_nx;
   logic [LW-1:0] line, line_nx, phase_last;
   logic [1:0]    pat_q;
   logic [BW-1:0] bar_px;
   logic [2:0]    bar_idx;
   logic          line_end, phase_end, frame_end, href_c;
   logic [7:0]    x, d_c;
   logic [3:0]    y;
   logic [11:0]   rgb;

   always_comb begin
      state_nx   = state;
      h_nx       = h;
      line_nx    = line;
      phase_last = '0;
      case (state)
         S_VSYNC:  phase_last = LW'(VS_LINES - 1);
         S_VBACK:  phase_last = LW'(V_BACK - 1);
         S_ACTIVE: phase_last = LW'(V_ACTIVE - 1);
         S_VFRONT: phase_last = LW'(V_FRONT - 1);
         default:  phase_last = '0;
      endcase
      line_end  = (h == H_LAST);
      phase_end = line_end && (line == phase_last);
      frame_end = (state == S_VFRONT) && phase_end;

      if (state == S_IDLE) begin
         h_nx    = '0;
         line_nx = '0;
         if (en) state_nx = S_VSYNC;
      end else if (!line_end) begin
         h_nx = h + 1'b1;
      end else begin
         h_nx = '0;
         if (phase_end) begin
            line_nx = '0;
            case (state)
               S_VSYNC:  state_nx = S_VBACK;
               S_VBACK:  state_nx = S_ACTIVE;
               S_ACTIVE: state_nx = S_VFRONT;
               S_VFRONT: state_nx = en ? S_VSYNC : S_IDLE;
               default:  state_nx = S_IDLE;
            endcase
         end else begin
            line_nx = line + 1'b1;
         end
      end
   end

   // Pixel generation works off the current counters; the result is registered.
   always_comb begin
      x   = 8'(h >> 1);
      y   = 4'(line);
      rgb = 12'h000;
      case (pat_q)
         2'd0: begin
            case (bar_idx)
               3'd0:    rgb = 12'hFFF;
               3'd1:    rgb = 12'hFF0;
               3'd2:    rgb = 12'h0FF;
               3'd3:    rgb = 12'h0F0;
               3'd4:    rgb = 12'hF0F;
               3'd5:    rgb = 12'hF00;
               3'd6:    rgb = 12'h00F;
               default: rgb = 12'h000;
            endcase
         end
         2'd1:    rgb = {x[3:0], y[3:0], x[7:4]};
         2'd2:    rgb = 12'hF00;
         default: rgb = (x[3] ^ y[3]) ? 12'hFFF : 12'h000;
      endcase
      href_c = (state == S_ACTIVE) && (h < H_HREF);
      d_c    = 8'h00;
      if (href_c) d_c = h[0] ? rgb[7:0] : {4'h0, rgb[11:8]};
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state      <= S_IDLE;
         h          <= '0;
         line       <= '0;
         pat_q      <= 2'd0;
         bar_px     <= '0;
         bar_idx    <= 3'd0;
         VSYNC      <= 1'b0;
         HREF       <= 1'b0;
         D          <= 8'h00;
         frame_done <= 1'b0;
         frame_cnt  <= 8'h00;
      end else begin
         state <= state_nx;
         h     <= h_nx;
         line  <= line_nx;
         if (state_nx == S_VSYNC && state != S_VSYNC) pat_q <= pattern_sel;
         // Bar position tracked incrementally to avoid dividing x by BAR_W.
         if (h_nx == '0) begin
            bar_px  <= '0;
            bar_idx <= 3'd0;
         end else if (h[0]) begin
            if (bar_px == BAR_LAST) begin
               bar_px  <= '0;
               bar_idx <= bar_idx + 3'd1;
            end else begin
               bar_px <= bar_px + 1'b1;
            end
         end
         VSYNC      <= (state == S_VSYNC);
         HREF       <= href_c;
         D          <= d_c;
         frame_done <= frame_end;
         if (frame_end) frame_cnt <= frame_cnt + 8'd1;
      end
   end

endmodule

// File: tb/tb_ov7670_dvp_source.sv
// Bench for ov7670_dvp_source: scoreboard of expected bytes and frame counts,
// checked by an independent monitor, plus per-frame timing measurement.
module tb_ov7670_dvp_source;

   localparam int HA = 16;

   logic       clk = 1'b0;
   logic       rst, en;
   logic [1:0] pattern_sel;
   logic       VSYNC, HREF, frame_done;
   logic [7:0] D, frame_cnt;

   int checks   = 0;
   int failures = 0;
   int exp_cnt  = 0;

   typedef struct {
      logic [7:0] d;
      int         y;
      int         hb;
   } exp_t;

   exp_t       bq[$];
   logic [7:0] fq[$];
   logic [7:0] cap [0:3][0:31];
   exp_t       mon_e;
   logic [7:0] mon_f;

   ov7670_dvp_source #(
      .H_ACTIVE(HA), .V_ACTIVE(4), .H_BLANK(4),
      .VS_LINES(1), .V_BACK(1), .V_FRONT(1)
   ) dut (
      .clk(clk), .rst(rst), .en(en), .pattern_sel(pattern_sel),
      .VSYNC(VSYNC), .HREF(HREF), .D(D),
      .frame_done(frame_done), .frame_cnt(frame_cnt)
   );

   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
      end
   endtask

   function automatic logic [7:0] exp_byte(input logic [1:0] p, input int x, input int y, input int ph);
      logic [11:0] c;
      c = 12'h000;
      case (p)
         2'd0: begin
            case (x / (HA/8))
               0: c = 12'hFFF;
               1: c = 12'hFF0;
               2: c = 12'h0FF;
               3: c = 12'h0F0;
               4: c = 12'hF0F;
               5: c = 12'hF00;
               6: c = 12'h00F;
               default: c = 12'h000;
            endcase
         end
         2'd1: c = {4'(x & 15), 4'(y & 15), 4'((x >> 4) & 15)};
         2'd2: c = 12'hF00;
         default: c = ((((x >> 3) ^ (y >> 3)) & 1) != 0) ? 12'hFFF : 12'h000;
      endcase
      return (ph != 0) ? c[7:0] : {4'h0, c[11:8]};
   endfunction

   task automatic push_frame(input logic [1:0] p);
      exp_t e;
      for (int yy = 0; yy < 4; yy++)
         for (int hb = 0; hb < 2*HA; hb++) begin
            e.d  = exp_byte(p, hb/2, yy, hb%2);
            e.y  = yy;
            e.hb = hb;
            bq.push_back(e);
         end
      exp_cnt = (exp_cnt + 1) % 256;
      fq.push_back(8'(exp_cnt));
   endtask

   // Monitor: pops expectations whenever the DUT presents a byte or frame_done.
   always @(negedge clk) begin
      if (rst === 1'b1) begin
         if (HREF) begin
            chk("href_vsync_overlap", VSYNC, 0);
            if (bq.size() == 0) begin
               checks++;
               failures++;
               $display("FAIL byte_unexpected actual=%0h expected=none", D);
            end else begin
               mon_e = bq.pop_front();
               cap[mon_e.y][mon_e.hb] = D;
               chk($sformatf("byte_y%0d_b%0d", mon_e.y, mon_e.hb), D, mon_e.d);
            end
         end else begin
            chk("d_when_href_low", D, 0);
         end
         if (frame_done) begin
            if (fq.size() == 0) begin
               checks++;
               failures++;
               $display("FAIL frame_done_unexpected actual=%0h expected=none", frame_cnt);
            end else begin
               mon_f = fq.pop_front();
               chk("frame_cnt_at_done", frame_cnt, mon_f);
            end
         end
      end
   end

   // Runs one frame from the current negedge, measuring its timing.
   task automatic run_frame(input int vs_exp, input int chg_t, input logic [1:0] chg_pat, input int drop_t);
      int vs_first = -1, vs_cnt = 0, href_first = -1, pulses = 0;
      int cur = 0, bad_len = 0, bad_gap = 0, last_fall = -1, fd = -1;
      push_frame(pattern_sel);
      for (int t = 1; t <= 600 && fd < 0; t++) begin
         @(negedge clk);
         if (VSYNC) begin
            if (vs_first < 0) vs_first = t;
            vs_cnt++;
         end
         if (HREF) begin
            if (href_first < 0) href_first = t;
            if (cur == 0) begin
               pulses++;
               if (last_fall >= 0 && t - last_fall != 4) bad_gap++;
            end
            cur++;
         end else if (cur > 0) begin
            if (cur != 32) bad_len++;
            cur = 0;
            last_fall = t;
         end
         if (frame_done) fd = t;
         if (t == chg_t) pattern_sel = chg_pat;
         if (t == drop_t) en = 1'b0;
      end
      chk("vsync_start", vs_first, vs_exp);
      chk("vsync_len", vs_cnt, 36);
      chk("href_offset", href_first - vs_first, 72);
      chk("href_pulses", pulses, 4);
      chk("href_len_bad", bad_len, 0);
      chk("href_gap_bad", bad_gap, 0);
      chk("frame_len", fd - vs_first + 1, 252);
   endtask

   initial begin
      rst = 1'b1;
      en = 1'b0;
      pattern_sel = 2'd0;
      #2 rst = 1'b0;
      repeat (3) @(negedge clk);
      chk("reset_outs", {VSYNC, HREF, frame_done, D, frame_cnt}, 0);
      rst = 1'b1;
      for (int i = 0; i < 500; i++) begin
         @(negedge clk);
         chk("idle_outs", {VSYNC, HREF, D, frame_cnt}, 0);
      end

      // Single frame from a one-clock en pulse, color bars.
      en = 1'b1;
      @(negedge clk);
      en = 1'b0;
      run_frame(1, -1, 2'd0, -1);
      chk("bar_white_b0", cap[0][0], 8'h0F);
      chk("bar_white_b1", cap[0][1], 8'hFF);
      chk("bar_yellow_b0", cap[0][4], 8'h0F);
      chk("bar_yellow_b1", cap[0][5], 8'hF0);
      chk("bar_red_b0", cap[0][20], 8'h0F);
      chk("bar_red_b1", cap[0][21], 8'h00);
      chk("bar_black", {cap[0][28], cap[0][29], cap[0][30], cap[0][31]}, 0);
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         chk("post_frame_idle", {VSYNC, HREF}, 0);
         chk("post_frame_cnt", frame_cnt, 1);
      end

      // 256 back-to-back frames, pattern changed mid-frame each time.
      pattern_sel = 2'd1;
      en = 1'b1;
      run_frame(2, 100, 2'd2, -1);
      chk("ramp_y2_x5_b0", cap[2][10], 8'h05);
      chk("ramp_y2_x5_b1", cap[2][11], 8'h20);
      for (int i = 1; i < 256; i++) begin
         run_frame(1, 100, 2'((i + 2) % 4), -1);
         if (i == 2) begin
            for (int b = 0; b < 16; b++) chk("checker_y0_low", cap[0][b], 8'h00);
            chk("checker_y0_x8", {cap[0][16], cap[0][17]}, 16'h0FFF);
         end
         if (i == 254) chk("frame_cnt_wrap", frame_cnt, 0);
      end

      // Asynchronous reset while HREF is high.
      push_frame(pattern_sel);
      begin
         int n = 0;
         while (!HREF && n < 300) begin
            @(negedge clk);
            n++;
         end
      end
      chk("href_before_reset", HREF, 1);
      #2 rst = 1'b0;
      bq.delete();
      fq.delete();
      exp_cnt = 0;
      #1 chk("reset_async", {VSYNC, HREF, D, frame_cnt}, 0);
      repeat (2) @(negedge clk);
      rst = 1'b1;
      run_frame(2, -1, 2'd0, 50);
      for (int i = 0; i < 30; i++) begin
         @(negedge clk);
         chk("idle_after_en_drop", {VSYNC, HREF}, 0);
      end
      chk("cnt_after_reset_frame", frame_cnt, 1);
      chk("bytes_left", bq.size(), 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
